// File: rtl/led_bank_pkg.sv
// Shared types for the LED bank write arbiter and its register bank.
package led_bank_pkg;

  localparam int NumReq = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CHECK
  } state_e;

  typedef logic [$clog2(NumReq)-1:0] req_idx_t;

  // A lone requester always wins; under contention the round-robin pointer decides.
  function automatic req_idx_t pick_winner(input logic [NumReq-1:0] req, input req_idx_t prio);
    if (req == 2'b11) return prio;
    else if (req[1])  return req_idx_t'(1);
    else              return req_idx_t'(0);
  endfunction

endpackage

// File: rtl/en_dffr_led.sv
// Single LED register cell: loads d_i when en_i is high, clears on reset.
module en_dffr_led (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  // Hold the stored LED bit, loading only when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= 1'b0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/led_bank.sv
// Bank of NumRegs LED cells sharing clock, reset and the data line.
module led_bank #(
  parameter int NumRegs = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               d_i,
  input  logic [NumRegs-1:0] en_i,
  output logic [NumRegs-1:0] q_o
);

  for (genvar g = 0; g < NumRegs; g++) begin : g_cell
    en_dffr_led u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i[g]),
      .d_i    (d_i),
      .q_o    (q_o[g])
    );
  end

endmodule

// File: rtl/led_bank_write_arbiter.sv
// Two-requester write arbiter for the LED register bank: grants one write,
// pulses the cell enable, then confirms the write from the cell readback.
module led_bank_write_arbiter
  import led_bank_pkg::*;
#(
  parameter int NumRegs   = 10,
  parameter int AddrWidth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumReq-1:0]                 data_i,
  output logic [NumReq-1:0]                 ack_o,
  output logic                              err_o,
  output logic [NumRegs-1:0]                en_o,
  output logic                              d_o,
  input  logic [NumRegs-1:0]                q_i
);

  state_e                 state_q, state_d;
  req_idx_t               prio_q, prio_d;
  req_idx_t               id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   data_q, data_d;
  logic                   rng_err_q, rng_err_d;
  logic [NumRegs-1:0]     en_q, en_d;

  req_idx_t               win;
  logic [AddrWidth-1:0]   win_addr;
  logic                   rd_bit;

  assign win      = pick_winner(req_i, prio_q);
  assign win_addr = addr_i[win];

  // Next-state, transaction capture and one-hot enable decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rng_err_d = rng_err_q;
    en_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          id_d      = win;
          addr_d    = win_addr;
          data_d    = data_i[win];
          rng_err_d = ({1'b0, win_addr} >= (AddrWidth + 1)'(NumRegs));
          if (rng_err_d) begin
            state_d = CHECK;
          end else begin
            state_d = WRITE;
            for (int i = 0; i < NumRegs; i++) en_d[i] = (win_addr == AddrWidth'(i));
          end
        end
      end
      WRITE: state_d = CHECK;
      CHECK: begin
        // With two requesters the one not served is simply the other index.
        prio_d  = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, round-robin pointer, latched transaction and registered enables.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prio_q    <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= 1'b0;
      rng_err_q <= 1'b0;
      en_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      prio_q    <= prio_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rng_err_q <= rng_err_d;
      en_q      <= en_d;
    end
  end

  // Select the readback bit of the latched cell; out-of-range addresses read 0.
  always_comb begin
    rd_bit = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_q == AddrWidth'(i)) rd_bit = q_i[i];
    end
  end

  assign en_o  = en_q;
  assign d_o   = data_q;
  assign ack_o = (state_q == CHECK) ? (NumReq'(1) << id_q) : '0;
  assign err_o = (state_q == CHECK) && (rng_err_q || (rd_bit != data_q));

endmodule
